// File: rtl/gray_world_wb.sv
// gray_world_wb
//   Gray-world white balance for the HDMI video path, one pixel per clock.
//   Per-channel sums are accumulated over each active frame. At the frame
//   boundary (i_vsync rising edge) the previous frame's sums are snapshotted.
//   One shared restoring divider then computes
//     gain_c = ((Sr+Sg+Sb) << GF) / (3*Sc), saturated to GMAX.
//   New gains are committed to a shadow set and become active on the
//   following frame boundary, so gains never change mid-frame.
//
//   Build option: define GRAY_WB_IIR_EN to smooth gains at commit with
//   shadow += (target - shadow) >>> IIR_SH. Undefined: shadow = target.
//
// Ports
//   clk, rst            pixel clock, synchronous active-high reset
//   en                  1: apply gains, 0: pass pixels through (same latency)
//   update              1: recompute gains at frame end, 0: hold gains
//   i_hsync/i_vsync/i_de, i_r/i_g/i_b, i_x/i_y   input timing, pixel, coords
//   o_hsync/o_vsync/o_de, o_r/o_g/o_b, o_x/o_y   outputs, 3 cycles later
//   gain_r/gain_g/gain_b  gains currently applied (GI.GF fixed point)
//   busy                gain computation in progress
module gray_world_wb #(
  parameter  int DW     = 8,
  parameter  int H_ACT  = 1280,
  parameter  int V_ACT  = 720,
  parameter  int GF     = 8,
  parameter  int GI     = 2,
  parameter  int IIR_SH = 2,
  localparam int X_W    = $clog2(H_ACT),
  localparam int Y_W    = $clog2(V_ACT),
  localparam int GAIN_W = GI + GF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              update,
  input  logic              i_hsync,
  input  logic              i_vsync,
  input  logic              i_de,
  input  logic [DW-1:0]     i_r,
  input  logic [DW-1:0]     i_g,
  input  logic [DW-1:0]     i_b,
  input  logic [X_W-1:0]    i_x,
  input  logic [Y_W-1:0]    i_y,
  output logic              o_hsync,
  output logic              o_vsync,
  output logic              o_de,
  output logic [DW-1:0]     o_r,
  output logic [DW-1:0]     o_g,
  output logic [DW-1:0]     o_b,
  output logic [X_W-1:0]    o_x,
  output logic [Y_W-1:0]    o_y,
  output logic [GAIN_W-1:0] gain_r,
  output logic [GAIN_W-1:0] gain_g,
  output logic [GAIN_W-1:0] gain_b,
  output logic              busy
);

  localparam int SUM_W = DW + $clog2(H_ACT * V_ACT);
  // wide enough for (3*S) << GAIN_W and for (Sr+Sg+Sb) << GF
  localparam int WW    = SUM_W + 3 + GAIN_W;
  localparam int CW    = $clog2(GAIN_W + 1);
  localparam int PW    = DW + GAIN_W;
  localparam logic [GAIN_W-1:0] GMAX = '1;
  localparam logic [GAIN_W-1:0] GONE = GAIN_W'(1) << GF;

`ifdef GRAY_WB_IIR_EN
  localparam int BLEND_SH = IIR_SH;
`else
  // a zero shift makes the commit blend collapse to shadow = target
  localparam int BLEND_SH = 0 * IIR_SH;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_DIV_R,
    S_DIV_G,
    S_DIV_B,
    S_COMMIT
  } state_t;

  state_t state, state_next;

  // ---------------------------------------------------------------------------
  // Frame statistics
  // ---------------------------------------------------------------------------
  logic             vsync_d;
  logic             frame_seen;
  logic             frame_edge;
  logic             start;
  logic [SUM_W-1:0] sum_r, sum_g, sum_b;
  logic [SUM_W-1:0] snap_r, snap_g, snap_b;

  assign frame_edge = i_vsync & ~vsync_d;
  assign start      = frame_edge & update & frame_seen & (state == S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_d    <= 1'b0;
      frame_seen <= 1'b0;
      sum_r      <= '0;
      sum_g      <= '0;
      sum_b      <= '0;
      snap_r     <= '0;
      snap_g     <= '0;
      snap_b     <= '0;
    end else begin
      vsync_d <= i_vsync;
      if (frame_edge) begin
        // the edge-cycle pixel is deliberately not counted
        frame_seen <= 1'b1;
        sum_r      <= '0;
        sum_g      <= '0;
        sum_b      <= '0;
        if (start) begin
          snap_r <= sum_r;
          snap_g <= sum_g;
          snap_b <= sum_b;
        end
      end else if (i_de) begin
        sum_r <= sum_r + SUM_W'(i_r);
        sum_g <= sum_g + SUM_W'(i_g);
        sum_b <= sum_b + SUM_W'(i_b);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Gain FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  logic [CW-1:0] cnt;
  logic          last_step;

  assign last_step = (cnt == CW'(GAIN_W));

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (start) state_next = S_LATCH;
      S_LATCH:  state_next = S_DIV_R;
      S_DIV_R:  if (last_step) state_next = S_DIV_G;
      S_DIV_G:  if (last_step) state_next = S_DIV_B;
      S_DIV_B:  if (last_step) state_next = S_COMMIT;
      S_COMMIT: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);

  // ---------------------------------------------------------------------------
  // Shared restoring divider
  //   cnt == 0        : check cycle (load remainder, decide saturation)
  //   cnt == 1..GAIN_W: quotient bit GAIN_W-cnt, MSB first
  //   Saturated channels still run the iterations so timing is fixed.
  // ---------------------------------------------------------------------------
  logic [WW-1:0]     n_reg, rem, d_cur, trial;
  logic [GAIN_W-1:0] quo, q_next;
  logic [GAIN_W-1:0] tgt_r, tgt_g, tgt_b;
  logic [GAIN_W-1:0] shadow_r, shadow_g, shadow_b;
  logic [GAIN_W-1:0] active_r, active_g, active_b;
  logic [CW-1:0]     bit_idx;
  logic              sat, take;

  always_comb begin
    d_cur = '0;
    case (state)
      S_DIV_R: d_cur = (WW'(snap_r) << 1) + WW'(snap_r);
      S_DIV_G: d_cur = (WW'(snap_g) << 1) + WW'(snap_g);
      S_DIV_B: d_cur = (WW'(snap_b) << 1) + WW'(snap_b);
      default: d_cur = '0;
    endcase
  end

  assign bit_idx = CW'(GAIN_W) - cnt;
  assign trial   = d_cur << bit_idx;
  assign take    = (cnt != '0) && (rem >= trial);
  assign q_next  = take ? (quo | (GAIN_W'(1) << bit_idx)) : quo;

  function automatic logic [GAIN_W-1:0] blend(input logic [GAIN_W-1:0] cur,
                                              input logic [GAIN_W-1:0] tgt);
    logic signed [GAIN_W+1:0] diff;
    logic signed [GAIN_W+1:0] acc;
    diff = $signed({2'b00, tgt}) - $signed({2'b00, cur});
    acc  = $signed({2'b00, cur}) + (diff >>> BLEND_SH);
    if (acc[GAIN_W+1])    blend = '0;
    else if (acc[GAIN_W]) blend = GMAX;
    else                  blend = acc[GAIN_W-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      n_reg    <= '0;
      rem      <= '0;
      quo      <= '0;
      sat      <= 1'b0;
      tgt_r    <= GONE;
      tgt_g    <= GONE;
      tgt_b    <= GONE;
      shadow_r <= GONE;
      shadow_g <= GONE;
      shadow_b <= GONE;
      active_r <= GONE;
      active_g <= GONE;
      active_b <= GONE;
    end else begin
      if (frame_edge) begin
        active_r <= shadow_r;
        active_g <= shadow_g;
        active_b <= shadow_b;
      end
      case (state)
        S_LATCH: begin
          n_reg <= (WW'(snap_r) + WW'(snap_g) + WW'(snap_b)) << GF;
          cnt   <= '0;
        end
        S_DIV_R, S_DIV_G, S_DIV_B: begin
          if (cnt == '0) begin
            rem <= n_reg;
            quo <= '0;
            sat <= (d_cur == '0) || ((d_cur << GAIN_W) <= n_reg);
            cnt <= cnt + CW'(1);
          end else begin
            if (take) rem <= rem - trial;
            quo <= q_next;
            if (last_step) begin
              cnt <= '0;
              case (state)
                S_DIV_R: tgt_r <= sat ? GMAX : q_next;
                S_DIV_G: tgt_g <= sat ? GMAX : q_next;
                S_DIV_B: tgt_b <= sat ? GMAX : q_next;
                default: ;
              endcase
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        S_COMMIT: begin
          shadow_r <= blend(shadow_r, tgt_r);
          shadow_g <= blend(shadow_g, tgt_g);
          shadow_b <= blend(shadow_b, tgt_b);
        end
        default: ;
      endcase
    end
  end

  assign gain_r = active_r;
  assign gain_g = active_g;
  assign gain_b = active_b;

  // ---------------------------------------------------------------------------
  // Pixel datapath: register -> multiply -> shift/clamp (or bypass)
  // ---------------------------------------------------------------------------
  function automatic logic [DW-1:0] scale(input logic [PW-1:0] p);
    logic [PW-1:0] s;
    s = p >> GF;
    if (|s[PW-1:DW]) scale = '1;
    else             scale = s[DW-1:0];
  endfunction

  logic           s1_en, s1_hs, s1_vs, s1_de;
  logic [DW-1:0]  s1_r, s1_g, s1_b;
  logic [X_W-1:0] s1_x;
  logic [Y_W-1:0] s1_y;
  logic           s2_en, s2_hs, s2_vs, s2_de;
  logic [DW-1:0]  s2_r, s2_g, s2_b;
  logic [PW-1:0]  p2_r, p2_g, p2_b;
  logic [X_W-1:0] s2_x;
  logic [Y_W-1:0] s2_y;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_en <= 1'b0; s1_hs <= 1'b0; s1_vs <= 1'b0; s1_de <= 1'b0;
      s1_r  <= '0;   s1_g  <= '0;   s1_b  <= '0;
      s1_x  <= '0;   s1_y  <= '0;
      s2_en <= 1'b0; s2_hs <= 1'b0; s2_vs <= 1'b0; s2_de <= 1'b0;
      s2_r  <= '0;   s2_g  <= '0;   s2_b  <= '0;
      p2_r  <= '0;   p2_g  <= '0;   p2_b  <= '0;
      s2_x  <= '0;   s2_y  <= '0;
      o_hsync <= 1'b0; o_vsync <= 1'b0; o_de <= 1'b0;
      o_r   <= '0;   o_g   <= '0;   o_b   <= '0;
      o_x   <= '0;   o_y   <= '0;
    end else begin
      s1_en <= en;      s1_hs <= i_hsync; s1_vs <= i_vsync; s1_de <= i_de;
      s1_r  <= i_r;     s1_g  <= i_g;     s1_b  <= i_b;
      s1_x  <= i_x;     s1_y  <= i_y;

      s2_en <= s1_en;   s2_hs <= s1_hs;   s2_vs <= s1_vs;   s2_de <= s1_de;
      s2_r  <= s1_r;    s2_g  <= s1_g;    s2_b  <= s1_b;
      s2_x  <= s1_x;    s2_y  <= s1_y;
      p2_r  <= PW'(s1_r) * PW'(active_r);
      p2_g  <= PW'(s1_g) * PW'(active_g);
      p2_b  <= PW'(s1_b) * PW'(active_b);

      o_hsync <= s2_hs; o_vsync <= s2_vs; o_de <= s2_de;
      o_x     <= s2_x;  o_y     <= s2_y;
      o_r     <= s2_en ? scale(p2_r) : s2_r;
      o_g     <= s2_en ? scale(p2_g) : s2_g;
      o_b     <= s2_en ? scale(p2_b) : s2_b;
    end
  end

endmodule

// File: tb/tb_gray_world_wb.sv
`timescale 1ns/1ps
module tb_gray_world_wb;

  localparam int DW = 8, H_ACT = 4, V_ACT = 2, GF = 8, GI = 2, IIR_SH = 2;
  localparam int X_W = 2, Y_W = 1, GAIN_W = 10;
  localparam int GMAX = 1023, ONE = 256, BUSY_CYC = 35;

  logic              clk = 1'b0;
  logic              rst, en, update;
  logic              i_hsync, i_vsync, i_de;
  logic [DW-1:0]     i_r, i_g, i_b;
  logic [X_W-1:0]    i_x;
  logic [Y_W-1:0]    i_y;
  logic              o_hsync, o_vsync, o_de;
  logic [DW-1:0]     o_r, o_g, o_b;
  logic [X_W-1:0]    o_x;
  logic [Y_W-1:0]    o_y;
  logic [GAIN_W-1:0] gain_r, gain_g, gain_b;
  logic              busy;

  gray_world_wb #(
    .DW(DW), .H_ACT(H_ACT), .V_ACT(V_ACT), .GF(GF), .GI(GI), .IIR_SH(IIR_SH)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .update(update),
    .i_hsync(i_hsync), .i_vsync(i_vsync), .i_de(i_de),
    .i_r(i_r), .i_g(i_g), .i_b(i_b), .i_x(i_x), .i_y(i_y),
    .o_hsync(o_hsync), .o_vsync(o_vsync), .o_de(o_de),
    .o_r(o_r), .o_g(o_g), .o_b(o_b), .o_x(o_x), .o_y(o_y),
    .gain_r(gain_r), .gain_g(gain_g), .gain_b(gain_b), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { int r; int g; int b; int x; int y; int hs; } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: frame-level gain bookkeeping
  int m_act[3];
  int m_shd[3];
  int m_sum[3];
  bit m_seen;

  function automatic int target(input int tot, input int sc);
    longint q;
    if (sc == 0) return GMAX;
    q = (longint'(tot) * ONE) / (3 * sc);
    return (q > GMAX) ? GMAX : int'(q);
  endfunction

  function automatic int next_shadow(input int cur, input int tgt);
`ifdef GRAY_WB_IIR_EN
    int v;
    v = cur + ((tgt - cur) >>> IIR_SH);
    if (v < 0) v = 0;
    if (v > GMAX) v = GMAX;
    return v;
`else
    return tgt;
`endif
  endfunction

  function automatic int apply(input int p, input int g);
    int v;
    v = (p * g) / ONE;
    return (v > 255) ? 255 : v;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 3; c++) begin
      m_act[c] = ONE;
      m_shd[c] = ONE;
      m_sum[c] = 0;
    end
    m_seen = 1'b0;
  endtask

  // Frame boundary plus vertical blanking long enough for the gain update.
  task automatic edge_frame(input bit upd);
    int  tot, bc;
    bit  snap;
    @(negedge clk);
    i_vsync = 1'b1; update = upd; i_de = 1'b0; i_hsync = 1'b0;
    for (int c = 0; c < 3; c++) m_act[c] = m_shd[c];
    snap = upd && m_seen;
    if (snap) begin
      tot = m_sum[0] + m_sum[1] + m_sum[2];
      for (int c = 0; c < 3; c++) m_shd[c] = next_shadow(m_shd[c], target(tot, m_sum[c]));
    end
    m_seen = 1'b1;
    for (int c = 0; c < 3; c++) m_sum[c] = 0;
    @(negedge clk);
    i_vsync = 1'b0;
    check("gain_r", gain_r, m_act[0]);
    check("gain_g", gain_g, m_act[1]);
    check("gain_b", gain_b, m_act[2]);
    bc = busy ? 1 : 0;
    repeat (BUSY_CYC + 4) begin
      @(negedge clk);
      if (busy) bc++;
    end
    check("busy_cycles", bc, snap ? BUSY_CYC : 0);
  endtask

  task automatic pixel_frame(input int kind);
    for (int y = 0; y < V_ACT; y++) begin
      for (int x = 0; x < H_ACT; x++) begin
        int   p[3];
        bit   pe;
        exp_t e;
        @(negedge clk);
        case (kind)
          1: begin p[0] = 100; p[1] = 100; p[2] = 100; end
          2: begin p[0] = 50;  p[1] = 100; p[2] = 200; end
          3: begin p[0] = 0;   p[1] = 128; p[2] = 128; end
          4: begin p[0] = 255; p[1] = $urandom_range(0, 255); p[2] = $urandom_range(0, 255); end
          5: for (int c = 0; c < 3; c++) p[c] = $urandom_range(0, 15);
          6: begin p[0] = $urandom_range(0, 3); p[1] = $urandom_range(0, 255); p[2] = $urandom_range(0, 255); end
          default: for (int c = 0; c < 3; c++) p[c] = $urandom_range(0, 255);
        endcase
        pe = ($urandom_range(0, 3) != 0);
        i_de = 1'b1; en = pe; i_hsync = 1'($urandom_range(0, 1));
        i_r = DW'(p[0]); i_g = DW'(p[1]); i_b = DW'(p[2]);
        i_x = X_W'(x);   i_y = Y_W'(y);
        for (int c = 0; c < 3; c++) m_sum[c] += p[c];
        e.r  = pe ? apply(p[0], m_act[0]) : p[0];
        e.g  = pe ? apply(p[1], m_act[1]) : p[1];
        e.b  = pe ? apply(p[2], m_act[2]) : p[2];
        e.x  = x; e.y = y; e.hs = int'(i_hsync);
        sb.push_back(e);
      end
      @(negedge clk);
      i_de = 1'b0; i_hsync = 1'b0; en = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
  endtask

  // Reset while the divider is working on the green channel.
  task automatic mid_reset();
    @(negedge clk);
    i_vsync = 1'b1; update = 1'b1;
    @(negedge clk);
    i_vsync = 1'b0;
    repeat (13) @(negedge clk);
    check("busy_before_rst", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_gain_r", gain_r, ONE);
    check("rst_gain_g", gain_g, ONE);
    check("rst_gain_b", gain_b, ONE);
    rst = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
  endtask

  // Scoreboard monitor: one entry per valid output pixel
  always @(negedge clk) begin
    if (!rst && o_de) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check("o_r", o_r, mon_e.r);
        check("o_g", o_g, mon_e.g);
        check("o_b", o_b, mon_e.b);
        check("o_x", o_x, mon_e.x);
        check("o_y", o_y, mon_e.y);
        check("o_hsync", o_hsync, mon_e.hs);
        check("o_vsync", o_vsync, 0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; en = 1'b1; update = 1'b1;
    i_hsync = 1'b0; i_vsync = 1'b0; i_de = 1'b0;
    i_r = '0; i_g = '0; i_b = '0; i_x = '0; i_y = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_o_r", o_r, 0);
    check("rst_o_g", o_g, 0);
    check("rst_o_b", o_b, 0);
    check("rst_o_de", o_de, 0);
    check("rst_o_hsync", o_hsync, 0);
    check("rst_o_vsync", o_vsync, 0);
    check("rst_busy", busy, 0);
    check("rst_gain_r", gain_r, ONE);
    check("rst_gain_g", gain_g, ONE);
    check("rst_gain_b", gain_b, ONE);
    rst = 1'b0;

    // neutral scene, then (50,100,200), then zero red followed by full red
    edge_frame(1); pixel_frame(1);
    edge_frame(1); pixel_frame(1);
    edge_frame(1); pixel_frame(2);
    edge_frame(1); pixel_frame(2);
    edge_frame(1); pixel_frame(2);
    edge_frame(1); pixel_frame(3);
    edge_frame(1); pixel_frame(4);
    edge_frame(1); pixel_frame(4);
    // hold gains while the scene changes
    edge_frame(0); pixel_frame(0);
    edge_frame(0); pixel_frame(5);
    edge_frame(1); pixel_frame(0);
    mid_reset();
    for (int i = 0; i < 16; i++) begin
      edge_frame($urandom_range(0, 3) != 0);
      pixel_frame($urandom_range(0, 6));
    end
    edge_frame(1);
    repeat (8) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
